// File: rtl/fetch_queue.sv
// Instruction fetch queue: credit-limited fetch from a one-cycle synchronous memory into a
// DEPTH-entry {pc, instr} FIFO; a branch flushes the queue and redirects in the same cycle.
module fetch_queue #(
  parameter int            AW       = 16,
  parameter int            DW       = 16,
  parameter int            DEPTH    = 4,
  parameter logic [AW-1:0] RESET_PC = '0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          branch,
  input  logic [AW-1:0] branch_tgt,
  output logic          mem_rd_en,
  output logic [AW-1:0] mem_addr,
  input  logic [DW-1:0] mem_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [AW-1:0] out_pc,
  output logic [DW-1:0] out_instr
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [AW-1:0] pc_q, pc_d;
  logic          inflight_q;
  logic [AW-1:0] tag_q;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] credit_used;
  logic          push, pop;

  logic [AW-1:0] fifo_pc_q    [DEPTH];
  logic [DW-1:0] fifo_instr_q [DEPTH];

  // Entries held plus the one response still on its way back from memory.
  assign credit_used = count_q + CW'(inflight_q);

  assign mem_rd_en = !rst && (branch || (credit_used < CW'(DEPTH)));
  assign mem_addr  = branch ? branch_tgt : pc_q;

  assign out_valid = (count_q != '0);
  assign out_pc    = fifo_pc_q[rd_ptr_q];
  assign out_instr = fifo_instr_q[rd_ptr_q];

  assign push = inflight_q && !branch;
  assign pop  = out_valid && out_ready && !branch;

  always_comb begin
    pc_d     = mem_rd_en ? mem_addr + AW'(1) : pc_q;
    rd_ptr_d = rd_ptr_q + PW'(pop);
    wr_ptr_d = wr_ptr_q + PW'(push);
    count_d  = count_q + CW'(push) - CW'(pop);
    if (branch) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q       <= RESET_PC;
      inflight_q <= 1'b0;
      tag_q      <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      pc_q       <= pc_d;
      inflight_q <= mem_rd_en;
      tag_q      <= mem_addr;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
    end
  end

  // Storage needs no reset: count_q alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_pc_q[wr_ptr_q]    <= tag_q;
      fifo_instr_q[wr_ptr_q] <= mem_data;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: a queue-based reference model checked every cycle,
// plus literal expectations at the interesting points of each scenario.
module tb_fetch_queue;
  localparam int DEPTH = 4;

  typedef struct packed {
    logic [15:0] pc;
    logic [15:0] instr;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        branch = 1'b0;
  logic [15:0] branch_tgt = 16'h0;
  logic        out_ready = 1'b1;
  logic [15:0] mem_data = 16'h0;
  logic        mem_rd_en;
  logic [15:0] mem_addr;
  logic        out_valid;
  logic [15:0] out_pc;
  logic [15:0] out_instr;

  logic [15:0] mem_data2 = 16'h0;
  logic        mem_rd_en2;
  logic [15:0] mem_addr2;
  logic        out_valid2;
  logic [15:0] out_pc2;
  logic [15:0] out_instr2;

  int vectors = 0;
  int miscompares = 0;

  ent_t        mq[$];
  ent_t        ent;
  logic [15:0] m_pc = 16'h0;
  logic        m_infl = 1'b0;
  logic [15:0] m_tag = 16'h0;
  logic        exp_rd;
  logic [15:0] exp_addr;
  logic [15:0] mem_next = 16'h0;
  logic [15:0] mem_next2 = 16'h0;
  logic [15:0] wrap_exp [3] = '{16'hFFFE, 16'hFFFF, 16'h0000};
  int          nreq;

  fetch_queue #(.AW(16), .DW(16), .DEPTH(DEPTH), .RESET_PC(16'h0000)) dut (
    .clk(clk), .rst(rst), .branch(branch), .branch_tgt(branch_tgt),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_data(mem_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_instr(out_instr)
  );

  fetch_queue #(.AW(16), .DW(16), .DEPTH(DEPTH), .RESET_PC(16'hFFFE)) dut_wrap (
    .clk(clk), .rst(rst), .branch(1'b0), .branch_tgt(16'h0000),
    .mem_rd_en(mem_rd_en2), .mem_addr(mem_addr2), .mem_data(mem_data2),
    .out_valid(out_valid2), .out_ready(1'b1), .out_pc(out_pc2), .out_instr(out_instr2)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] mem_fn(input logic [15:0] a);
    return a + 16'h0100;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory: answers the request seen this cycle one clock later.
  always @(posedge clk) begin
    #1;
    mem_data  = mem_next;
    mem_data2 = mem_next2;
  end

  // Reference model and per-cycle comparison.
  always @(negedge clk) begin
    mem_next  = mem_rd_en  ? mem_fn(mem_addr)  : 16'hBAD0;
    mem_next2 = mem_rd_en2 ? mem_fn(mem_addr2) : 16'hBAD0;
    if (rst) begin
      check("rst_out_valid", 32'(out_valid), 0);
      check("rst_mem_rd_en", 32'(mem_rd_en), 0);
      mq.delete();
      m_pc   = 16'h0000;
      m_infl = 1'b0;
    end else begin
      exp_rd   = branch || ((mq.size() + int'(m_infl)) < DEPTH);
      exp_addr = branch ? branch_tgt : m_pc;
      check("model_mem_rd_en", 32'(mem_rd_en), 32'(exp_rd));
      if (exp_rd) check("model_mem_addr", 32'(mem_addr), 32'(exp_addr));
      check("model_out_valid", 32'(out_valid), 32'(mq.size() != 0));
      if (mq.size() != 0) begin
        check("model_out_pc", 32'(out_pc), 32'(mq[0].pc));
        check("model_out_instr", 32'(out_instr), 32'(mq[0].instr));
      end
      if (branch) begin
        mq.delete();
      end else begin
        if (mq.size() != 0 && out_ready) void'(mq.pop_front());
        if (m_infl) begin
          ent.pc    = m_tag;
          ent.instr = mem_fn(m_tag);
          mq.push_back(ent);
        end
      end
      m_infl = exp_rd;
      m_tag  = exp_addr;
      if (exp_rd) m_pc = exp_addr + 16'h0001;
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic probe();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    branch = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time %0t, required finish earlier", $time);
    $fatal(1);
  end

  initial begin
    repeat (2) tick();

    // Streaming from reset, plus the RESET_PC=0xFFFE instance wrapping.
    rst = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      probe();
      if (c == 0) begin
        check("a_first_rd_en", 32'(mem_rd_en), 1);
        check("a_first_addr", 32'(mem_addr), 32'h0000);
        check("a_first_valid", 32'(out_valid), 0);
      end
      if (c == 1) check("wrap_valid_c1", 32'(out_valid2), 0);
      if (c >= 2 && c <= 5) begin
        check("a_out_valid", 32'(out_valid), 1);
        check("a_out_pc", 32'(out_pc), 32'(c - 2));
        check("a_out_instr", 32'(out_instr), 32'(16'h0100 + c - 2));
      end
      if (c >= 2 && c <= 4) check("wrap_out_pc", 32'(out_pc2), 32'(wrap_exp[c-2]));
      tick();
    end

    // Decode stalled: queue fills to DEPTH and fetch stops.
    out_ready = 1'b0;
    do_reset();
    nreq = 0;
    for (int c = 0; c < 10; c++) begin
      probe();
      nreq += int'(mem_rd_en);
      if (c >= 2) check("b_head_pc_stable", 32'(out_pc), 32'h0000);
      if (c == 9) begin
        check("b_rd_en_off", 32'(mem_rd_en), 0);
        check("b_out_valid", 32'(out_valid), 1);
      end
      tick();
    end
    check("b_request_count", 32'(nreq), 4);

    // Branch out of a full queue.
    branch = 1'b1;
    branch_tgt = 16'h0040;
    probe();
    check("c_branch_rd_en", 32'(mem_rd_en), 1);
    check("c_branch_addr", 32'(mem_addr), 32'h0040);
    tick();
    branch = 1'b0;
    out_ready = 1'b1;
    probe();
    check("c_flushed_valid", 32'(out_valid), 0);
    tick();
    probe();
    check("c_head_tgt", 32'(out_pc), 32'h0040);
    tick();
    probe();
    check("c_head_tgt1", 32'(out_pc), 32'h0041);
    tick();
    for (int c = 0; c < 12; c++) begin
      out_ready = (c % 3) != 0;
      tick();
    end

    // Branch while pc=5 is in flight and the head is being popped.
    out_ready = 1'b1;
    do_reset();
    for (int c = 0; c < 10; c++) begin
      branch = (c == 6);
      branch_tgt = 16'h0080;
      probe();
      check("d_no_pc5", 32'(out_valid && out_pc == 16'h0005), 0);
      if (c == 6) check("d_head_before", 32'(out_pc), 32'h0004);
      if (c == 7) check("d_flushed_valid", 32'(out_valid), 0);
      if (c == 8) check("d_head_tgt", 32'(out_pc), 32'h0080);
      if (c == 9) check("d_head_tgt1", 32'(out_pc), 32'h0081);
      tick();
    end

    // Back-to-back branches: the first target is dropped.
    for (int c = 0; c < 6; c++) begin
      branch = (c < 2);
      branch_tgt = (c == 0) ? 16'h0010 : 16'h0020;
      probe();
      if (c == 3) check("e_second_tgt", 32'(out_pc), 32'h0020);
      tick();
    end

    // Branch near the top of the address space wraps.
    for (int c = 0; c < 6; c++) begin
      branch = (c == 0);
      branch_tgt = 16'hFFFE;
      probe();
      if (c >= 2 && c <= 4) check("f_wrap_pc", 32'(out_pc), 32'(wrap_exp[c-2]));
      tick();
    end

    // Asynchronous reset mid-cycle with three entries queued.
    out_ready = 1'b0;
    do_reset();
    for (int c = 0; c < 4; c++) begin
      branch = (c == 0);
      branch_tgt = 16'h0020;
      tick();
    end
    branch = 1'b0;
    #1;
    check("g_pre_rst_valid", 32'(out_valid), 1);
    check("g_pre_rst_pc", 32'(out_pc), 32'h0020);
    rst = 1'b1;
    #1;
    check("g_rst_valid", 32'(out_valid), 0);
    check("g_rst_rd_en", 32'(mem_rd_en), 0);
    tick();
    rst = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      probe();
      if (c == 0) check("g_restart_addr", 32'(mem_addr), 32'h0000);
      if (c == 1) check("g_no_stale", 32'(out_valid), 0);
      if (c == 2) begin
        check("g_first_pc", 32'(out_pc), 32'h0000);
        check("g_first_instr", 32'(out_instr), 32'h0100);
      end
      if (c == 3) check("g_second_pc", 32'(out_pc), 32'h0001);
      tick();
    end

    probe();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
